// File: rtl/sid_pkg.sv
// Shared constants, waveform bit indices and LFSR parameters for the SID voice.
package sid_pkg;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;
  localparam int PH_W = 12;

  localparam int WAVE_TRI = 0;
  localparam int WAVE_SAW = 1;
  localparam int WAVE_PULSE = 2;
  localparam int WAVE_NOISE = 3;

  localparam int LFSR_W = 23;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8;
  localparam int LFSR_TAP_A = 22;
  localparam int LFSR_TAP_B = 17;

  function automatic logic [OUT_W-1:0] to_smp(
    input logic [PH_W-1:0] w
  );
    return {~w[PH_W-1], w[PH_W-2:0], 4'b0000};
  endfunction
endpackage

// File: rtl/sid_noise_lfsr.sv
// 23-bit Fibonacci noise LFSR; hold reloads the seed, step shifts once.
module sid_noise_lfsr
  import sid_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              hold,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst || hold) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-2:0],
               lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
    end
  end

endmodule

// File: rtl/sid_voice.sv
// SID-style oscillator voice: phase accumulator, tri/saw/pulse waveforms.
// Noise waveform is built only when SID_VOICE_NOISE_EN is defined.
module sid_voice
  import sid_pkg::*;
#(
  parameter int ACC_W = sid_pkg::ACC_W,
  parameter int OUT_W = sid_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [15:0]      freq,
  input  logic [11:0]      pw,
  input  logic [3:0]       wave,
  input  logic             test,
  output logic [OUT_W-1:0] smp,
  output logic             smp_valid
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] phase;
  logic             v1;
  logic [PH_W-1:0]  p;
  logic [PH_W-1:0]  w_tri;
  logic [PH_W-1:0]  w_pulse;
  logic [PH_W-1:0]  w_noise;
  logic             use_noise;
  logic [PH_W-1:0]  w;
  logic             unused_bits;

  assign acc_sum = acc + ACC_W'(freq);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= tick;
      if (test) begin
        acc <= '0;
      end else if (tick) begin
        acc <= acc_sum;
      end
    end
  end

  // test forces phase zero for the sample being emitted as well
  assign phase = test ? '0 : acc;
  assign p     = phase[23:12];
  assign w_tri = phase[23] ? ~phase[22:11] : phase[22:11];
  assign w_pulse = (p >= pw) ? 12'hFFF : 12'h000;
  assign unused_bits = ^phase[10:0];

`ifdef SID_VOICE_NOISE_EN
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] nsrc;
  logic              step;

  assign step = tick && !acc[19] && acc_sum[19];

  sid_noise_lfsr u_noise (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .hold (test),
    .lfsr (lfsr)
  );

  assign nsrc = test ? LFSR_SEED : lfsr;
  assign w_noise = {nsrc[20], nsrc[18], nsrc[14], nsrc[11],
                    nsrc[9], nsrc[5], nsrc[2], nsrc[0], 4'b0000};
  assign use_noise = wave[WAVE_NOISE];
`else
  logic unused_noise;
  assign unused_noise = wave[WAVE_NOISE];
  assign w_noise   = '0;
  assign use_noise = 1'b0;
`endif

  always_comb begin
    w = '1;
    if (wave[WAVE_TRI])   w = w & w_tri;
    if (wave[WAVE_SAW])   w = w & p;
    if (wave[WAVE_PULSE]) w = w & w_pulse;
    if (use_noise)        w = w & w_noise;
    if (!(wave[WAVE_TRI] || wave[WAVE_SAW] ||
          wave[WAVE_PULSE] || use_noise)) begin
      w = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp       <= '0;
      smp_valid <= 1'b0;
    end else begin
      smp_valid <= v1;
      if (v1) smp <= to_smp(w);
    end
  end

endmodule

// File: tb/tb_sid_voice.sv
// Directed self-checking bench for sid_voice.
module tb_sid_voice;
  import sid_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] freq = '0;
  logic [11:0] pw = '0;
  logic [3:0]  wave = '0;
  logic        test = 1'b0;
  logic [15:0] smp;
  logic        smp_valid;

  int total = 0;
  int bad = 0;

  sid_voice dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .freq      (freq),
    .pw        (pw),
    .wave      (wave),
    .test      (test),
    .smp       (smp),
    .smp_valid (smp_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) cyc();
    rst = 1'b0;
  endtask

  // n back-to-back ticks, then one idle cycle so the last sample is out
  task automatic run(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
    cyc();
  endtask

  function automatic logic [11:0] nz_w(input logic [22:0] l);
    return {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0], 4'b0000};
  endfunction

  function automatic logic [22:0] nz_shift(input logic [22:0] l);
    return {l[21:0], l[22] ^ l[17]};
  endfunction

  initial begin
    logic [22:0] ref_l;

    rst = 1'b1;
    repeat (4) cyc();
    chk("rst_smp", 32'(smp), 32'h0000);
    chk("rst_valid", 32'(smp_valid), 32'h0);
    rst = 1'b0;

    freq = 16'h1000;
    wave = 4'b0010;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("lat_v_t1", 32'(smp_valid), 32'h0);
    cyc();
    chk("lat_v_t2", 32'(smp_valid), 32'h1);
    chk("lat_smp", 32'(smp), 32'h8010);
    cyc();
    chk("lat_v_t3", 32'(smp_valid), 32'h0);
    chk("lat_hold", 32'(smp), 32'h8010);

    do_reset();
    tick = 1'b1;
    cyc();
    chk("b2b_v0", 32'(smp_valid), 32'h0);
    cyc();
    chk("b2b_v1", 32'(smp_valid), 32'h1);
    chk("b2b_s1", 32'(smp), 32'h8010);
    cyc();
    tick = 1'b0;
    chk("b2b_v2", 32'(smp_valid), 32'h1);
    chk("b2b_s2", 32'(smp), 32'h8020);
    cyc();
    chk("b2b_v3", 32'(smp_valid), 32'h1);
    chk("b2b_s3", 32'(smp), 32'h8030);
    cyc();
    chk("b2b_v4", 32'(smp_valid), 32'h0);

    tick = 1'b1;
    cyc();
    tick = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("flush_v1", 32'(smp_valid), 32'h0);
    cyc();
    chk("flush_v2", 32'(smp_valid), 32'h0);

    do_reset();
    freq = 16'hFFFF;
    wave = 4'b0010;
    run(257);
    chk("wrap_acc", 32'(dut.acc), 32'h00FEFF);
    chk("wrap_smp", 32'(smp), 32'h80F0);

    do_reset();
    wave = 4'b0100;
    pw = 12'hFFF;
    run(255);
    chk("pwmax_lo", 32'(smp), 32'h8000);
    run(1);
    chk("pwmax_hi", 32'(smp), 32'h7FF0);

    do_reset();
    freq = 16'h0000;
    pw = 12'h000;
    run(1);
    chk("pw0", 32'(smp), 32'h7FF0);

    do_reset();
    freq = 16'h0100;
    pw = 12'h800;
    run(16);
    chk("pulse_p1", 32'(smp), 32'h8000);
    run(32751);
    chk("pulse_7ff", 32'(smp), 32'h8000);
    run(1);
    chk("pulse_800", 32'(smp), 32'h7FF0);

    do_reset();
    freq = 16'h3000;
    wave = 4'b0010;
    run(1);
    chk("mix_saw", 32'(smp), 32'h8030);
    freq = 16'h0000;
    wave = 4'b0011;
    run(1);
    chk("mix_and", 32'(smp), 32'h8020);
    wave = 4'b0001;
    run(1);
    chk("mix_tri", 32'(smp), 32'h8060);
    wave = 4'b0010;
    test = 1'b1;
    run(1);
    chk("test_smp", 32'(smp), 32'h8000);
    chk("test_valid", 32'(smp_valid), 32'h1);
    test = 1'b0;
    freq = 16'h3000;
    run(1);
    chk("test_resume", 32'(smp), 32'h8030);
    chk("test_acc", 32'(dut.acc), 32'h003000);

    do_reset();
    freq = 16'h1000;
    wave = 4'b0000;
    run(1);
    chk("wave0", 32'(smp), 32'h8000);
    wave = 4'b1000;
    run(1);
`ifdef SID_VOICE_NOISE_EN
    chk("noise_seed", 32'(smp), 32'(to_smp(nz_w(LFSR_SEED))));
`else
    chk("noise_off", 32'(smp), 32'h8000);
`endif

`ifdef SID_VOICE_NOISE_EN
    do_reset();
    freq = 16'h0100;
    wave = 4'b1000;
    ref_l = LFSR_SEED;
    run(2047);
    chk("nz_noshift", 32'(dut.lfsr), 32'(ref_l));
    chk("nz_smp0", 32'(smp), 32'(to_smp(nz_w(ref_l))));
    run(1);
    ref_l = nz_shift(ref_l);
    chk("nz_shift1", 32'(dut.lfsr), 32'(ref_l));
    chk("nz_smp1", 32'(smp), 32'(to_smp(nz_w(ref_l))));
`else
    ref_l = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
